seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//  Parametrised, time-multiplexed N:1 channel selector for the visitor-counter display path.
//  Cycles through N_CH W-bit input channels, presenting one channel at a time on data_out.
//  Drives a matching one-hot enable (digit anode) for the channel being shown.
//  Additions: masked channels are skipped; blanking gaps prevent ghosting;
//  a manual-select mode and a frame-complete pulse are provided.
// PARAMETERS
//  N_CH       8     number of input channels (>=2)
//  W          4     bits per channel (BCD digit default)
//  DWELL      1000  clk cycles each channel is shown (>=1)
//  BLANK_CYC  2     clk cycles of all-off enable between channels (>=1)
//  SEL_W      $clog2(N_CH)  localparam, not overridable
// PORTS
//  clk        in   1           system clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  en         in   1           1 = scanning active; 0 = outputs blanked, FSM idle
//  mode       in   1           0 = auto scan; 1 = manual (channel = man_sel)
//  man_sel    in   SEL_W       manual channel index
//  ch_mask    in   N_CH        bit i = 1 -> channel i participates in scan
//  data_in    in   N_CH*W      flattened channels, ch i = data_in[i*W +: W]
//  data_out   out  W           selected channel data (registered)
//  an_out     out  N_CH        one-hot active-high enable of shown channel, 0 when blanked
//  sel_out    out  SEL_W       index of current channel
//  frame_tick out  1           1-cycle pulse on auto-scan wrap to lowest enabled channel
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, cnt=0; data_out=0, an_out=0, sel_out=0, frame_tick=0.
//  States: IDLE, BLANK, SHOW (2-bit encoding). cnt = one dwell/blank counter, width clog2(max(DWELL,BLANK_CYC)+1).
//  IDLE: an_out=0, data_out=0. en=1 -> BLANK. sel = first enabled channel (auto) or man_sel (manual); cnt=0.
//  BLANK: an_out=0 for BLANK_CYC cycles; data_out already tracks new sel. Then -> SHOW, cnt=0.
//  SHOW: an_out[sel]=1 for DWELL cycles. At cnt==DWELL-1, load next sel and -> BLANK.
//  Next sel, auto: lowest enabled index > sel; else wrap to lowest enabled index (frame_tick=1, same edge).
//  Next sel, manual: man_sel. frame_tick stays 0. man_sel/mode changes take effect only at dwell end.
//  Single enabled channel: it repeats, with BLANK gaps. frame_tick pulses every dwell end.
//  Dwell-end check, ch_mask==0 (auto): -> BLANK, sel held; stays blanked; rechecks every BLANK_CYC+DWELL-equivalent boundary.
//  ch_mask==0 rule: enters SHOW only when some mask bit is 1 at the BLANK->SHOW edge.
//  Mask change mid-SHOW: current dwell completes. Next sel uses ch_mask sampled at dwell end.
//  Manual, man_sel >= N_CH: treated as invalid; an_out stays 0 through SHOW; data_out=0.
//  en=0 in any state: -> IDLE on the next edge. an_out=0, data_out=0 from that edge, cnt=0.
//  data_out <= data_in[sel*W +: W] every cycle outside IDLE (1-cycle latency to live data changes).
//  an_out and sel_out registered; all outputs change only on clk edges (glitch-free to pads).
// STRUCTURE
//  Shared package: state encoding constants (ST_IDLE/ST_BLANK/ST_SHOW), default DWELL/BLANK_CYC values.
//  Sub-module scan_next_sel (combinational): inputs sel, ch_mask; outputs next index, wrap flag, any_en.
//  Priority search, parametrised on N_CH. Everything else (FSM, counter, output regs) lives in seg_scan_mux.
// TESTING  (bench params N_CH=4, W=4, DWELL=3, BLANK_CYC=1)
//  Inputs for all cases: data_in=16'h4321 (ch0=1 .. ch3=4).
//  1 Reset/enable: rst pulse, then en=1, mask=4'hF, mode=0
//    -> an_out=0 during reset/BLANK.
//    -> an_out pattern 0001 x3, 0000 x1, 0010 x3, 0000, 0100 x3, 0000, 1000 x3.
//    -> data_out = 1,2,3,4 aligned to each SHOW.
//  2 Wrap/frame: continue case 1
//    -> after ch3 dwell, frame_tick=1 for exactly one cycle, then an_out=0001.
//    -> frame period 16 cycles.
//  3 Masking: mask=4'b1010
//    -> only an_out 0010/1000 alternate; data_out 2,4; frame_tick each time ch3 ends.
//    -> mask->0: an_out held 0.
//  4 Manual: mode=1, man_sel=2 mid-SHOW of ch0
//    -> ch0 completes 3 cycles, then only 0100/data_out=3 repeats; frame_tick never asserts.
//  5 Async reset mid-SHOW: assert rst between edges
//    -> an_out, data_out, sel_out read 0 immediately (before next edge).
//    -> after release, scan restarts at ch0.
//  6 en drop / live data: en=0 during SHOW -> an_out=0 next edge.
//    -> en=1 while showing ch1 with data_in[7:4] 2->9: data_out=9 one cycle later.

Source files
------------

// File: rtl/seg_scan_mux_pkg.sv
// rtl/seg_scan_mux_pkg.sv - shared state encoding and default timing for the digit scanner
package seg_scan_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam int DEF_DWELL     = 1000;
  localparam int DEF_BLANK_CYC = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_next_sel.sv
// rtl/scan_next_sel.sv - priority search for the next enabled channel in the scan order
module scan_next_sel
  import seg_scan_mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [SEL_W-1:0] i_sel,
  input  logic [N_CH-1:0]  i_ch_mask,
  output logic [SEL_W-1:0] o_next_sel,
  output logic [SEL_W-1:0] o_first_sel,
  output logic             o_wrap,
  output logic             o_any_en
);

  logic w_up;

  // lowest enabled index, lowest enabled index above i_sel, and wrap when none is above
  always_comb begin
    o_first_sel = '0;
    o_next_sel  = '0;
    w_up        = 1'b0;
    o_any_en    = |i_ch_mask;
    // walking downwards lets the lowest qualifying index win
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_ch_mask[i]) begin
        o_first_sel = SEL_W'(i);
      end
      if (i_ch_mask[i] && (SEL_W'(i) > i_sel)) begin
        o_next_sel = SEL_W'(i);
        w_up       = 1'b1;
      end
    end
    if (!w_up) begin
      o_next_sel = o_any_en ? o_first_sel : i_sel;
    end
    o_wrap = o_any_en && !w_up;
  end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - time-multiplexed N:1 digit selector with blanking, masking and manual select
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter  int N_CH      = 8,
  parameter  int W         = 4,
  parameter  int DWELL     = DEF_DWELL,
  parameter  int BLANK_CYC = DEF_BLANK_CYC,
  localparam int SEL_W     = $clog2(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic [SEL_W-1:0]  i_man_sel,
  input  logic [N_CH-1:0]   i_ch_mask,
  input  logic [N_CH*W-1:0] i_data_in,
  output logic [W-1:0]      o_data_out,
  output logic [N_CH-1:0]   o_an_out,
  output logic [SEL_W-1:0]  o_sel_out,
  output logic              o_frame_tick
);

  localparam int CNT_MAX = max_int(DWELL, BLANK_CYC);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_DWELL_END = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYC - 1);

  scan_state_t      r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  // r_hold: blank slot stretched by one dwell because no channel was enabled
  logic             r_hold, w_hold_nxt;
  // r_man: mode latched when the current channel was chosen
  logic             r_man, w_man_nxt;
  logic             w_tick_nxt;
  logic [W-1:0]     r_data, w_data;
  logic [N_CH-1:0]  r_an, w_an;

  logic [SEL_W-1:0] w_next_sel, w_first_sel;
  logic             w_wrap, w_any_en;

  scan_next_sel #(.N_CH(N_CH)) u_next_sel (
    .i_sel       (r_sel),
    .i_ch_mask   (i_ch_mask),
    .o_next_sel  (w_next_sel),
    .o_first_sel (w_first_sel),
    .o_wrap      (w_wrap),
    .o_any_en    (w_any_en)
  );

  // next-state, dwell/blank counting and channel selection
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_hold_nxt  = r_hold;
    w_man_nxt   = r_man;
    w_tick_nxt  = 1'b0;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_hold_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_man_nxt   = i_mode;
          w_sel_nxt   = i_mode ? i_man_sel : w_first_sel;
        end
        ST_BLANK: begin
          if (r_hold) begin
            if (r_cnt == CNT_DWELL_END) begin
              w_hold_nxt = 1'b0;
              w_cnt_nxt  = '0;
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end else if (r_cnt == CNT_BLANK_END) begin
            w_cnt_nxt = '0;
            if (r_man) begin
              w_state_nxt = ST_SHOW;
            end else if (w_any_en) begin
              w_state_nxt = ST_SHOW;
              // mask may have dropped the chosen channel during the gap
              if (!i_ch_mask[r_sel]) begin
                w_sel_nxt = w_next_sel;
              end
            end else begin
              w_hold_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        ST_SHOW: begin
          if (r_cnt == CNT_DWELL_END) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            w_man_nxt   = i_mode;
            if (i_mode) begin
              w_sel_nxt = i_man_sel;
            end else if (w_any_en) begin
              w_sel_nxt  = w_next_sel;
              w_tick_nxt = w_wrap;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_hold_nxt  = 1'b0;
        end
      endcase
    end
  end

  // pad values derived from the upcoming state so every output moves on the same edge
  always_comb begin
    w_an   = '0;
    w_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_sel_nxt == SEL_W'(i)) begin
        if ((w_state_nxt == ST_SHOW) && !w_hold_nxt) begin
          w_an[i] = 1'b1;
        end
        if (w_state_nxt != ST_IDLE) begin
          w_data = i_data_in[i*W +: W];
        end
      end
    end
  end

  // state register and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_sel        <= '0;
      r_hold       <= 1'b0;
      r_man        <= 1'b0;
      r_data       <= '0;
      r_an         <= '0;
      o_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel        <= w_sel_nxt;
      r_hold       <= w_hold_nxt;
      r_man        <= w_man_nxt;
      r_data       <= w_data;
      r_an         <= w_an;
      o_frame_tick <= w_tick_nxt;
    end
  end

  assign o_data_out = r_data;
  assign o_an_out   = r_an;
  assign o_sel_out  = r_sel;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - randomized scoreboard bench for the digit scanner
module tb_seg_scan_mux;

  localparam int N_CH      = 4;
  localparam int W         = 4;
  localparam int DWELL     = 3;
  localparam int BLANK_CYC = 1;
  localparam int SEL_W     = 2;

  typedef struct packed {
    logic [W-1:0]     data;
    logic [N_CH-1:0]  an;
    logic [SEL_W-1:0] sel;
    logic             tick;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              mode;
  logic [SEL_W-1:0]  man_sel;
  logic [N_CH-1:0]   ch_mask;
  logic [N_CH*W-1:0] data_in;
  logic [W-1:0]      data_out;
  logic [N_CH-1:0]   an_out;
  logic [SEL_W-1:0]  sel_out;
  logic              frame_tick;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // model: a slot is BLANK_CYC gap cycles followed by DWELL show cycles
  int   m_active, m_ch, m_pos;
  bit   m_man, m_dark;
  exp_t m_out;

  seg_scan_mux #(.N_CH(N_CH), .W(W), .DWELL(DWELL), .BLANK_CYC(BLANK_CYC)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_mode       (mode),
    .i_man_sel    (man_sel),
    .i_ch_mask    (ch_mask),
    .i_data_in    (data_in),
    .o_data_out   (data_out),
    .o_an_out     (an_out),
    .o_sel_out    (sel_out),
    .o_frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [N_CH-1:0] mk);
    for (int j = 0; j < N_CH; j++) if (mk[j]) return j;
    return -1;
  endfunction

  function automatic int next_after(input int ch, input logic [N_CH-1:0] mk);
    for (int j = ch + 1; j < N_CH; j++) if (mk[j]) return j;
    return lowest(mk);
  endfunction

  task automatic check_out(input string name, input exp_t e);
    exp_t a;
    a.data = data_out;
    a.an   = an_out;
    a.sel  = sel_out;
    a.tick = frame_tick;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t: got data=%h an=%b sel=%0d tick=%b, want data=%h an=%b sel=%0d tick=%b",
               name, $time, a.data, a.an, a.sel, a.tick, e.data, e.an, e.sel, e.tick);
    end
  endtask

  // predicts outputs after the coming edge from the inputs that edge will sample
  task automatic model_step();
    int nx;
    m_out.tick = 1'b0;
    if (rst) begin
      m_active = 0; m_ch = 0; m_pos = 0; m_dark = 0; m_man = 0;
      m_out = '0;
      return;
    end
    if (!en) begin
      m_active = 0;
    end else if (m_active == 0) begin
      m_active = 1;
      m_pos    = 0;
      m_dark   = 0;
      m_man    = mode;
      if (mode) m_ch = int'(man_sel);
      else m_ch = (lowest(ch_mask) < 0) ? 0 : lowest(ch_mask);
    end else begin
      m_pos++;
      if (m_pos == BLANK_CYC && !m_man) begin
        if (ch_mask == '0) m_dark = 1;
        else if (!ch_mask[m_ch]) m_ch = next_after(m_ch, ch_mask);
      end
      if (m_pos == BLANK_CYC + DWELL) begin
        m_pos = 0;
        if (!m_dark) begin
          m_man = mode;
          if (mode) begin
            m_ch = int'(man_sel);
          end else if (ch_mask != '0) begin
            nx = next_after(m_ch, ch_mask);
            m_out.tick = (nx <= m_ch);
            m_ch = nx;
          end
        end
        m_dark = 0;
      end
    end
    m_out.sel  = SEL_W'(m_ch);
    m_out.an   = '0;
    m_out.data = '0;
    if (m_active != 0) begin
      m_out.data = data_in[m_ch*W +: W];
      if (m_pos >= BLANK_CYC && !m_dark) m_out.an[m_ch] = 1'b1;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit md, input logic [SEL_W-1:0] ms,
                      input logic [N_CH-1:0] mk, input logic [N_CH*W-1:0] d);
    bit rise;
    @(negedge clk);
    #1;
    rise    = r && !rst;
    rst     = r;
    en      = e;
    mode    = md;
    man_sel = ms;
    ch_mask = mk;
    data_in = d;
    model_step();
    exp_q.push_back(m_out);
    if (rise) begin
      #1;
      check_out("async_reset", '0);
    end
  endtask

  // monitor: compares each registered output set against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_out("scan", e);
      end
    end
  end

  initial begin
    bit c_rst, c_en, c_mode;
    logic [SEL_W-1:0] c_ms;
    logic [N_CH-1:0] c_mask;
    logic [N_CH*W-1:0] c_data;
    rst = 1'b1; en = 1'b0; mode = 1'b0; man_sel = '0; ch_mask = '0; data_in = 16'h4321;
    #1;
    check_out("reset_state", '0);
    repeat (2) step(1, 0, 0, 0, 4'hF, 16'h4321);
    // full auto scan with frame wrap
    repeat (40) step(0, 1, 0, 0, 4'hF, 16'h4321);
    // masked scan, then no channels, then a single channel
    repeat (40) step(0, 1, 0, 0, 4'b1010, 16'h4321);
    repeat (14) step(0, 1, 0, 0, 4'b0000, 16'h4321);
    repeat (20) step(0, 1, 0, 0, 4'b0100, 16'h4321);
    // back to full scan, then manual select of channel 2
    repeat (9)  step(0, 1, 0, 0, 4'hF, 16'h4321);
    repeat (30) step(0, 1, 1, 2, 4'hF, 16'h4321);
    // async reset mid-scan and restart
    repeat (6)  step(0, 1, 0, 0, 4'hF, 16'h4321);
    step(1, 1, 0, 0, 4'hF, 16'h4321);
    repeat (20) step(0, 1, 0, 0, 4'hF, 16'h4321);
    // enable drop, then live data change on channel 1
    step(0, 0, 0, 0, 4'hF, 16'h4321);
    repeat (6) step(0, 1, 0, 0, 4'hF, 16'h4321);
    repeat (4) step(0, 1, 0, 0, 4'hF, 16'h4391);
    repeat (8) step(0, 1, 0, 0, 4'hF, 16'h4321);
    // random soak
    c_en = 1; c_mode = 0; c_ms = 0; c_mask = 4'hF; c_data = 16'h4321;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) c_mask = N_CH'($urandom);
      if ($urandom_range(0, 39) == 0) c_mode = ~c_mode;
      if ($urandom_range(0, 9) == 0)  c_ms = SEL_W'($urandom);
      if ($urandom_range(0, 49) == 0) c_en = ~c_en;
      if ($urandom_range(0, 3) == 0)  c_data = (N_CH*W)'($urandom);
      c_rst = ($urandom_range(0, 149) == 0);
      step(c_rst, c_en, c_mode, c_ms, c_mask, c_data);
    end
    repeat (3) @(posedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
